// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects, MEM-dependence stall and divide-busy hold
// for the five-stage MIPS pipeline, plus a count of decode-stall cycles.
module hazard_unit #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  rsE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  writeRegAddrM,
    input  logic        regWriteM,
    input  logic        memToRegM,
    input  logic        divStartE,
    output logic [1:0]  forwardAE,
    output logic [1:0]  forwardBE,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        flushE,
    output logic        divBusy,
    output logic [31:0] stallCount
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } divState_t;

    // The counter starts one below DIV_CYCLES because the start cycle itself
    // already occupies EX; BUSY then lasts DIV_CYCLES-1 cycles.
    localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 1);

    divState_t  state;
    divState_t  nextState;
    logic [5:0] cnt;
    logic [5:0] nextCnt;
    logic       memProducer;
    logic       depStall;

    // A MEM instruction can only supply a value if it writes a nonzero register.
    assign memProducer = regWriteM && (writeRegAddrM != 5'd0);

    // Pick the MEM-stage source for each EX operand: load data or ALU result.
    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (memProducer && (writeRegAddrM == rsE)) begin
            forwardAE = memToRegM ? 2'b10 : 2'b01;
        end
        if (memProducer && (writeRegAddrM == rtE)) begin
            forwardBE = memToRegM ? 2'b10 : 2'b01;
        end
    end

    // Without a WB-to-EX path, a decode operand produced in MEM waits a cycle
    // so that the write-first register file supplies it.
    assign depStall = memProducer &&
                      ((writeRegAddrM == rsD) || (writeRegAddrM == rtD));

    // Divide sequencing: hold EX for the divide's duration, then release once.
    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        unique case (state)
            IDLE: begin
                if (divStartE) begin
                    nextState = BUSY;
                    nextCnt   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt == 6'd1) begin
                    nextState = DONE;
                end
                nextCnt = cnt - 6'd1;
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
                nextCnt   = 6'd0;
            end
        endcase
    end

    // Divide FSM register; reset aborts any divide in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

    assign divBusy = (state == BUSY);
    assign stallE  = divBusy;
    assign stallF  = divBusy | depStall;
    assign stallD  = divBusy | depStall;
    // A held EX instruction must not be replaced by a bubble during a divide.
    assign flushE  = depStall & ~divBusy;

    // Performance counter of cycles in which decode was held.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCount <= 32'd0;
        end else if (stallD) begin
            stallCount <= stallCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: randomized and directed stimulus, expected responses queued
// by a cycle-level reference model and compared by an independent monitor.
module tb_hazard_unit;

    localparam int DIVC = 4;

    logic        clk;
    logic        rst;
    logic [4:0]  rsD, rtD, rsE, rtE, writeRegAddrM;
    logic        regWriteM, memToRegM, divStartE;
    logic [1:0]  forwardAE, forwardBE;
    logic        stallF, stallD, stallE, flushE, divBusy;
    logic [31:0] stallCount;

    hazard_unit #(.DIV_CYCLES(DIVC)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeRegAddrM(writeRegAddrM), .regWriteM(regWriteM),
        .memToRegM(memToRegM), .divStartE(divStartE),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushE(flushE),
        .divBusy(divBusy), .stallCount(stallCount)
    );

    typedef struct {
        int          cyc;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        sF;
        logic        sD;
        logic        sE;
        logic        fE;
        logic        busy;
        logic [31:0] cnt;
    } expect_t;

    expect_t expQ[$];
    int      testsRun = 0;
    int      testsFailed = 0;

    // Reference model: the divide is described by the span of cycles it owns.
    int          cyc = 0;
    int          busyFrom = -100;
    int          busyTo = -100;
    int          doneAt = -100;
    logic [31:0] modelCount = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] modelFwd(input logic rw, input logic m2r,
                                            input logic [4:0] wr, input logic [4:0] src);
        if (rw && wr != 0 && wr == src) return m2r ? 2'd2 : 2'd1;
        return 2'd0;
    endfunction

    // Drive one cycle of inputs, record what the DUT must show, advance model.
    task automatic applyStimulus(input logic r, input logic [4:0] d_rs, input logic [4:0] d_rt,
                                 input logic [4:0] e_rs, input logic [4:0] e_rt,
                                 input logic [4:0] wr, input logic rw, input logic m2r,
                                 input logic ds);
        expect_t e;
        logic    busy, idle, dep;
        @(posedge clk);
        #1;
        rst = r; rsD = d_rs; rtD = d_rt; rsE = e_rs; rtE = e_rt;
        writeRegAddrM = wr; regWriteM = rw; memToRegM = m2r; divStartE = ds;
        busy = (cyc >= busyFrom) && (cyc <= busyTo);
        idle = !busy && (cyc != doneAt);
        dep  = rw && (wr != 0) && (wr == d_rs || wr == d_rt);
        e.cyc  = cyc;
        e.fa   = modelFwd(rw, m2r, wr, e_rs);
        e.fb   = modelFwd(rw, m2r, wr, e_rt);
        e.sD   = busy || dep;
        e.sF   = e.sD;
        e.sE   = busy;
        e.fE   = dep && !busy;
        e.busy = busy;
        e.cnt  = modelCount;
        expQ.push_back(e);
        if (r) begin
            modelCount = 0;
            busyFrom = -100; busyTo = -100; doneAt = -100;
        end else begin
            if (e.sD) modelCount = modelCount + 1;
            if (idle && ds) begin
                busyFrom = cyc + 1;
                busyTo   = cyc + DIVC - 1;
                doneAt   = cyc + DIVC;
            end
        end
        cyc++;
    endtask

    task automatic checkOutput(input string name, input int c,
                               input logic [31:0] act, input logic [31:0] req);
        testsRun++;
        if (act !== req) begin
            testsFailed++;
            $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, c, act, req);
        end
    endtask

    // Monitor: every cycle is an output; compare mid-cycle against the queue.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("forwardAE", e.cyc, 32'(forwardAE), 32'(e.fa));
                checkOutput("forwardBE", e.cyc, 32'(forwardBE), 32'(e.fb));
                checkOutput("stallF", e.cyc, 32'(stallF), 32'(e.sF));
                checkOutput("stallD", e.cyc, 32'(stallD), 32'(e.sD));
                checkOutput("stallE", e.cyc, 32'(stallE), 32'(e.sE));
                checkOutput("flushE", e.cyc, 32'(flushE), 32'(e.fE));
                checkOutput("divBusy", e.cyc, 32'(divBusy), 32'(e.busy));
                checkOutput("stallCount", e.cyc, stallCount, e.cnt);
            end
        end
    end

    initial begin
        int wait_cycles;
        rst = 1'b1; rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeRegAddrM = 0; regWriteM = 0; memToRegM = 0; divStartE = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state with quiet inputs.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // ALU forward to A only.
        applyStimulus(0, 1, 2, 8, 9, 8, 1, 0, 0);
        // Load forward to B.
        applyStimulus(0, 1, 2, 3, 9, 9, 1, 1, 0);
        // Register 0 never forwards.
        applyStimulus(0, 1, 2, 0, 0, 0, 1, 1, 0);
        // MEM dependence for one cycle, then producer moves on.
        applyStimulus(0, 5, 7, 3, 4, 5, 1, 0, 0);
        applyStimulus(0, 5, 7, 3, 4, 6, 1, 0, 0);
        // Divide with quiet surroundings, then a few idle cycles.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Divide overlapped by a decode dependence; start ignored while busy.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 5, 0, 5, 0, 5, 1, 0, 1);
        applyStimulus(0, 0, 5, 0, 5, 5, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Start together with a dependence, then reset mid-divide and restart.
        applyStimulus(0, 3, 0, 0, 0, 3, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic over a narrow register range to provoke matches.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom_range(0, 199) == 0),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0));
        end

        wait_cycles = 0;
        while (expQ.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(posedge clk);
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
